// File: rtl/dmem_responder.sv
// Load/store responder for the CPU memory stage: one request at a time,
// fixed access latency, single-cycle response strobe, word and byte lanes.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misaligned_err,
    output logic        stall
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam int unsigned CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW+1:0] addr_q;
    logic          read_q;
    logic          write_q;
    logic          word_q;
    logic [31:0]   wdata_q;
    logic          resp_valid_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW+1:0] cur_addr;
    logic          cur_read;
    logic          cur_write;
    logic          cur_word;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_idx;
    logic [1:0]    cur_lane;
    logic          cur_mis;
    logic          enter_resp;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [31:0]   rdata_d;
    logic          err_d;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    // With LATENCY=1 the response edge is the accept edge, so the live
    // request is used in IDLE; otherwise the latched copy drives the access.
    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = req_addr[AW+1:0];
            cur_read  = req_read;
            cur_write = req_write;
            cur_word  = req_word;
            cur_wdata = req_wdata;
        end else begin
            cur_addr  = addr_q;
            cur_read  = read_q;
            cur_write = write_q;
            cur_word  = word_q;
            cur_wdata = wdata_q;
        end
        cur_idx    = cur_addr[AW+1:2];
        cur_lane   = cur_addr[1:0];
        cur_mis    = cur_word && (cur_lane != 2'b00);
        enter_resp = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                     ((state_q == BUSY) && (cnt_q == '0));
        rd_word    = mem[cur_idx];

        wr_word = rd_word;
        if (cur_word) begin
            wr_word = cur_wdata;
        end else begin
            wr_word[{cur_lane, 3'b000} +: 8] = cur_wdata[7:0];
        end
        mem_we = enter_resp && cur_write && !cur_mis;

        err_d   = cur_mis && (cur_read || cur_write);
        rdata_d = '0;
        if (!cur_mis && cur_read && !cur_write) begin
            if (cur_word) begin
                rdata_d = rd_word;
            end else begin
                rdata_d = {24'b0, rd_word[{cur_lane, 3'b000} +: 8]};
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            word_q       <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= enter_resp;
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[AW+1:0];
                        read_q  <= req_read;
                        write_q <= req_write;
                        word_q  <= req_word;
                        wdata_q <= req_wdata;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(CNT_INIT);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array is not reset; a write on an edge where reset is low is dropped.
    always_ff @(posedge clock) begin
        if (rst && mem_we) begin
            mem[cur_idx] <= wr_word;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign stall          = (req_valid && (state_q == IDLE)) || (state_q == BUSY);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = rdata_q;
    assign misaligned_err = err_q;

endmodule
